// File: rtl/spi_slave_regs_if.sv
// Serial pins and register-bank port of spi_slave_regs, grouped for the DUT and its driver.
interface spi_slave_regs_if #(parameter int ADDR_W = 4);
  logic              sck;
  logic              cs_n;
  logic              mosi;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;

  modport slave  (input  sck, cs_n, mosi, reg_rdata,
                  output reg_addr, reg_wdata, reg_we, reg_re, busy);
  modport master (output sck, cs_n, mosi, reg_rdata,
                  input  reg_addr, reg_wdata, reg_we, reg_re, busy);
endinterface

// File: rtl/spi_slave_regs.sv
// Mode-3 SPI responder bridging an external master to a small register bank.
// SCK, CS_N and MOSI are oversampled by clk_i; nothing is clocked on SCK.
module spi_slave_regs #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  spi_slave_regs_if.slave bus,
  output wire             miso_o
);
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  localparam int FLUSH_W = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sckSync_q, csSync_q, mosiSync_q;
  logic                   sckPrev_q, csPrev_q;
  logic [FLUSH_W-1:0]     flushCnt_q;
  logic                   armed_q;
  state_t                 state_q;
  logic [2:0]             bitCnt_q;
  logic [6:0]             inShift_q;
  logic [7:0]             outShift_q, rdBuf_q, regWdata_q;
  logic [ADDR_W-1:0]      regAddr_q;
  logic                   rw_q, regWe_q, regRe_q, rePipe_q, loadNext_q, incPending_q;

  logic       sSck, sCs, sMosi, sckRise, sckFall, csRise, csFall, flushed;
  logic [7:0] byteIn;

  assign sSck    = sckSync_q[SYNC_STAGES-1];
  assign sCs     = csSync_q[SYNC_STAGES-1];
  assign sMosi   = mosiSync_q[SYNC_STAGES-1];
  assign sckRise = !sckPrev_q && sSck && !sCs;
  assign sckFall = sckPrev_q && !sSck && !sCs;
  assign csRise  = !csPrev_q && sCs;
  assign csFall  = csPrev_q && !sCs && armed_q;
  assign flushed = (flushCnt_q == FLUSH_W'(SYNC_STAGES));
  assign byteIn  = {inShift_q, sMosi};

  // The chip select only arms once the post-reset synchronizer contents have
  // flushed and a genuine high level is seen, so a CS_N held low through reset
  // cannot masquerade as a frame start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sckSync_q  <= '1;
      csSync_q   <= '1;
      mosiSync_q <= '0;
      sckPrev_q  <= 1'b1;
      csPrev_q   <= 1'b1;
      flushCnt_q <= '0;
      armed_q    <= 1'b0;
    end else begin
      sckSync_q  <= {sckSync_q[SYNC_STAGES-2:0], bus.sck};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], bus.cs_n};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], bus.mosi};
      sckPrev_q  <= sSck;
      csPrev_q   <= sCs;
      if (!flushed) flushCnt_q <= flushCnt_q + FLUSH_W'(1);
      if (flushed && sCs) armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      inShift_q    <= '0;
      outShift_q   <= '0;
      rdBuf_q      <= '0;
      regWdata_q   <= '0;
      regAddr_q    <= '0;
      rw_q         <= 1'b0;
      regWe_q      <= 1'b0;
      regRe_q      <= 1'b0;
      rePipe_q     <= 1'b0;
      loadNext_q   <= 1'b0;
      incPending_q <= 1'b0;
    end else begin
      regWe_q      <= 1'b0;
      regRe_q      <= 1'b0;
      incPending_q <= 1'b0;
      rePipe_q     <= regRe_q;
      // Bank data is taken two clocks after the read strobe went high.
      if (rePipe_q) rdBuf_q <= bus.reg_rdata;
      if (incPending_q) regAddr_q <= regAddr_q + ADDR_W'(1);

      if (csRise) begin
        state_q    <= IDLE;
        bitCnt_q   <= '0;
        loadNext_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (csFall) begin
              state_q    <= CMD;
              bitCnt_q   <= '0;
              inShift_q  <= '0;
              outShift_q <= '0;
            end
          end
          CMD: begin
            if (sckRise) begin
              inShift_q <= byteIn[6:0];
              bitCnt_q  <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                regAddr_q <= byteIn[ADDR_W-1:0];
                rw_q      <= byteIn[7];
                state_q   <= DATA;
                if (byteIn[7]) begin
                  regRe_q    <= 1'b1;
                  loadNext_q <= 1'b1;
                end
              end
            end
          end
          DATA: begin
            if (sckRise) begin
              inShift_q <= byteIn[6:0];
              bitCnt_q  <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                if (rw_q) begin
                  regAddr_q  <= regAddr_q + ADDR_W'(1);
                  regRe_q    <= 1'b1;
                  loadNext_q <= 1'b1;
                end else begin
                  regWdata_q   <= byteIn;
                  regWe_q      <= 1'b1;
                  incPending_q <= 1'b1;
                end
              end
            end else if (sckFall) begin
              if (loadNext_q) begin
                outShift_q <= rdBuf_q;
                loadNext_q <= 1'b0;
              end else begin
                outShift_q <= {outShift_q[6:0], 1'b0};
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.reg_addr  = regAddr_q;
  assign bus.reg_wdata = regWdata_q;
  assign bus.reg_we    = regWe_q;
  assign bus.reg_re    = regRe_q;
  assign bus.busy      = (state_q != IDLE);
  assign miso_o        = bus.cs_n ? 1'bz : outShift_q[7];
endmodule

// File: tb/tb_spi_slave_regs.sv
// Randomized bench for spi_slave_regs: frames are predicted from the command
// byte and a register-bank image, then compared against observed strobes and MISO.
module tb_spi_slave_regs;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  wire        misoLine;
  logic [7:0] bankRdata = 8'h00;

  spi_slave_regs_if #(.ADDR_W(ADDR_W)) bus ();
  pullup (misoLine);
  assign bus.reg_rdata = bankRdata;

  spi_slave_regs #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .miso_o(misoLine)
  );

  always #4 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0]          bankMem [DEPTH];
  logic [ADDR_W+7:0]   weLog [$];
  logic [ADDR_W-1:0]   reLog [$];
  logic [7:0]          txBytes [$];
  logic [7:0]          rxBytes [$];
  logic                dataNext = 1'b0;
  logic                garbageNext = 1'b0;
  logic [ADDR_W-1:0]   reAddr = '0;

  // Register-bank model: logs strobes and answers a read strobe with data
  // valid only during the window in which the responder should sample it.
  always @(negedge clk) begin
    if (garbageNext) begin
      bankRdata   = 8'($urandom);
      garbageNext = 1'b0;
    end
    if (dataNext) begin
      bankRdata   = bankMem[reAddr];
      dataNext    = 1'b0;
      garbageNext = 1'b1;
    end
    if (bus.reg_we) weLog.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re) begin
      reLog.push_back(bus.reg_addr);
      reAddr   = bus.reg_addr;
      dataNext = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic spiBits(input logic [7:0] txb, input int nbits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.sck  = 1'b0;
      bus.mosi = txb[i];
      repeat (8) @(negedge clk);
      rxb[i]  = misoLine;
      bus.sck = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic applyStimulus();
    logic [7:0] rxb;
    rxBytes.delete();
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    foreach (txBytes[k]) begin
      spiBits(txBytes[k], 8, rxb);
      rxBytes.push_back(rxb);
      if (k == 0) checkOutput("busy in frame", bus.busy, 1);
    end
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("busy after frame", bus.busy, 0);
    checkOutput("miso released", misoLine, 1);
  endtask

  // Predict a whole frame from the command byte and the bank image, run it, compare.
  task automatic runFrame(input string name);
    int                weBase, reBase, a;
    logic [7:0]        expMiso [$];
    logic [ADDR_W+7:0] expWe [$];
    logic [ADDR_W-1:0] expRe [$];
    a = int'(txBytes[0][ADDR_W-1:0]);
    expMiso.push_back(8'h00);
    if (txBytes[0][7]) begin
      expRe.push_back(ADDR_W'(a));
      for (int k = 1; k < txBytes.size(); k++) begin
        expMiso.push_back(bankMem[a]);
        a = (a + 1) % DEPTH;
        expRe.push_back(ADDR_W'(a));
      end
    end else begin
      for (int k = 1; k < txBytes.size(); k++) begin
        expWe.push_back({ADDR_W'(a), txBytes[k]});
        expMiso.push_back(8'h00);
        a = (a + 1) % DEPTH;
      end
    end
    weBase = weLog.size();
    reBase = reLog.size();
    applyStimulus();
    checkOutput({name, " we count"}, weLog.size() - weBase, expWe.size());
    foreach (expWe[k])
      if (weBase + k < weLog.size()) checkOutput({name, " we addr/data"}, weLog[weBase + k], expWe[k]);
    checkOutput({name, " re count"}, reLog.size() - reBase, expRe.size());
    foreach (expRe[k])
      if (reBase + k < reLog.size()) checkOutput({name, " re addr"}, reLog[reBase + k], expRe[k]);
    foreach (expMiso[k]) checkOutput({name, " miso byte"}, rxBytes[k], expMiso[k]);
    foreach (expWe[k]) bankMem[expWe[k][ADDR_W+7:8]] = expWe[k][7:0];
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    logic [7:0] rxb;
    int         weBase, reBase, len;
    bus.sck  = 1'b1;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    for (int i = 0; i < DEPTH; i++) bankMem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    checkOutput("reset busy", bus.busy, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("reset we", bus.reg_we, 0);
    checkOutput("reset re", bus.reg_re, 0);
    checkOutput("reset addr", bus.reg_addr, 0);
    checkOutput("reset wdata", bus.reg_wdata, 0);
    checkOutput("reset miso", misoLine, 1);

    txBytes = '{8'h03, 8'hA5};
    runFrame("write single");
    txBytes = '{8'h0F, 8'h11, 8'h22};
    runFrame("burst wrap");
    bankMem[5] = 8'h3C;
    bankMem[6] = 8'h7E;
    txBytes = '{8'h85, 8'h00, 8'h00};
    runFrame("read pair");
    checkOutput("read byte 1 literal", rxBytes[1], 8'h3C);
    checkOutput("read byte 2 literal", rxBytes[2], 8'h7E);

    for (int n = 0; n < 10; n++) begin
      txBytes.delete();
      txBytes.push_back(8'($urandom));
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) txBytes.push_back(8'($urandom));
      runFrame("random frame");
    end

    // Abort five bits into a data byte.
    weBase = weLog.size();
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    spiBits(8'h02, 8, rxb);
    spiBits(8'hC3, 5, rxb);
    bus.cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort miso", misoLine, 1);
    repeat (12) @(negedge clk);
    checkOutput("abort no we", weLog.size() - weBase, 0);
    txBytes = '{8'h02, 8'h5A};
    runFrame("after abort");

    // Reset in the middle of byte 1 while CS_N stays low.
    weBase = weLog.size();
    reBase = reLog.size();
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    spiBits(8'h07, 8, rxb);
    spiBits(8'h99, 3, rxb);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset busy", bus.busy, 0);
    checkOutput("midreset addr", bus.reg_addr, 0);
    checkOutput("midreset wdata", bus.reg_wdata, 0);
    checkOutput("midreset we", bus.reg_we, 0);
    checkOutput("midreset miso", misoLine, 0);
    spiBits(8'h81, 8, rxb);
    spiBits(8'h33, 8, rxb);
    spiBits(8'h44, 8, rxb);
    checkOutput("midreset busy held", bus.busy, 0);
    bus.cs_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("midreset no we", weLog.size() - weBase, 0);
    checkOutput("midreset no re", reLog.size() - reBase, 0);
    txBytes = '{8'h8C, 8'h00};
    runFrame("after midreset");

    // SCK noise with CS_N high.
    weBase = weLog.size();
    reBase = reLog.size();
    for (int i = 0; i < 20; i++) begin
      bus.sck  = ~bus.sck;
      bus.mosi = 1'($urandom);
      repeat (7) @(negedge clk);
      if (i == 10) checkOutput("noise busy", bus.busy, 0);
    end
    repeat (12) @(negedge clk);
    checkOutput("noise no we", weLog.size() - weBase, 0);
    checkOutput("noise no re", reLog.size() - reBase, 0);
    checkOutput("noise busy end", bus.busy, 0);
    checkOutput("noise miso", misoLine, 1);
    bus.sck = 1'b1;
    repeat (8) @(negedge clk);
    txBytes = '{8'h01, 8'hE7, 8'h18};
    runFrame("after noise");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
